counter_mod_ud: RTL and testbench
=================================

Name: counter_mod_ud

Overview:
- Parametrised up/down modulo counter; next generation of the fixed 24-bit free-running blink counter.
- Adds programmable terminal value, direction, clock enable, parallel load, a registered wrap pulse and a toggle (blink) output.
- Used as the timebase and LED-blink source in board top levels; drops in where the free-running counter was used when MAX = all-ones, UP = 1, CE = 1.

Parameters:
- WIDTH, 24, counter width in bits (>= 2)
- INIT, 0, reset value of O (must be <= 2^WIDTH-1)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous reset, active-high
- CE  input  1  count enable
- UP  input  1  direction: 1 = increment, 0 = decrement
- LD  input  1  parallel load strobe
- DATA  input  WIDTH  load value
- MAX  input  WIDTH  terminal value; count range is 0..MAX inclusive
- O  output  WIDTH  current count (registered)
- COUT  output  1  registered wrap pulse
- TOG  output  1  toggles on every wrap (blink output)

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is CLK and the reset port is RESET.
- Priority per edge: RESET > LD > CE. Everything is evaluated on the rising CLK edge.
- RESET: O <= INIT, COUT <= 0, TOG <= 0. A reset asserted mid-count takes effect at the next edge and discards any pending wrap.
- LD (RESET low):
  - O <= DATA if DATA <= MAX, else O <= MAX (clipped).
  - COUT <= 0; TOG holds.
- CE=1, UP=1:
  - If O >= MAX: O <= 0, COUT <= 1, TOG <= ~TOG. The ">" case covers MAX lowered below the current count.
  - Otherwise: O <= O+1, COUT <= 0.
- CE=1, UP=0:
  - If O == 0: O <= MAX, COUT <= 1, TOG <= ~TOG.
  - If O > MAX: O <= MAX, no wrap (COUT <= 0).
  - Otherwise: O <= O-1, COUT <= 0.
- CE=0: O and TOG hold; COUT <= 0.
- Wrap timing: COUT is high in the cycle after the wrapping edge, coincident with the new O value (0 when up, MAX when down). COUT is exactly one cycle wide per wrap.
- MAX = 0 with CE held high: O stays 0, wraps every cycle, COUT stays high continuously, TOG toggles every cycle.
- MAX = 2^WIDTH-1, UP=1: free-running binary counter. Wrap period is 2^WIDTH cycles.
- TOG period is 2*(MAX+1) enabled counts, 50% duty.
- Arithmetic is unsigned WIDTH-bit; no carry leaves the block other than COUT.
- Changing UP or MAX mid-count takes effect at the next edge; no extra state is kept.

Optional Feature:
- Macro COUNTER_MOD_UD_PRESCALE_EN.
- When defined:
  - Adds parameter PRE_WIDTH (default 8) and input PRE [PRE_WIDTH].
  - An internal prescaler counts CE-qualified cycles 0..PRE. The main counter advances only on the CE cycle where the prescaler equals PRE; the prescaler then returns to 0.
  - Prescaler clears on RESET and on LD.
  - PRE = 0 behaves identically to the macro being undefined.
  - COUT is still one cycle wide per main-counter wrap.
- When undefined: no PRE port and no prescaler logic; the counter advances on every CE cycle.

Test Plan:
- Reset value: WIDTH=8, INIT=5; RESET high 2 cycles, CE=1 -> O=5, COUT=0, TOG=0 during reset. First enabled edge after release gives O=6.
- Up wrap: MAX=9, UP=1, CE=1 from O=0 -> O goes 0..9,0; COUT high only in the cycle O returns to 0. TOG toggles at cycles 10 and 20; TOG period is 20 cycles.
- Down wrap and load clip:
  - MAX=9, LD with DATA=3 -> O=3; then UP=0 gives 2,1,0,9 with COUT high alongside the 9.
  - LD with DATA=200 -> O=9.
- Simultaneous events:
  - RESET=LD=CE=1 -> O=INIT.
  - LD=CE=1 with DATA=4 -> O=4, COUT=0.
  - CE=0 for 3 cycles -> O holds, COUT=0.
- Boundary:
  - MAX=0, CE=1 -> COUT=1 every cycle, TOG toggles every cycle.
  - WIDTH=24, MAX=24'hFFFFFF, start O=24'hFFFFFE -> FFFFFF, then 000000 with COUT=1.
  - MAX changed to 3 while O=7, UP=1 -> next O=0 with COUT=1.
- Prescale (macro defined): PRE=2, MAX=3, UP=1, CE=1 -> O advances every 3rd cycle. COUT is a single one-cycle pulse every 12 cycles. LD mid-period restarts the 3-cycle spacing.

Source files
------------

// File: rtl/counter_mod_ud.sv
// counter_mod_ud: parametrised up/down modulo counter with a programmable
// terminal value, clock enable, parallel load, a registered wrap pulse (COUT)
// and a blink output (TOG) that flips on every wrap.
//
// Count range is 0..MAX inclusive. Per-edge priority is RESET > LD > CE.
// COUT is high in the cycle after the wrapping edge, alongside the new O.
//
// Optional feature: define COUNTER_MOD_UD_PRESCALE_EN to add parameter
// PRE_WIDTH and input PRE. A prescaler then lets the main counter advance
// only on every (PRE+1)-th CE cycle. PRE = 0 gives the plain behaviour.
module counter_mod_ud #(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] INIT  = '0
`ifdef COUNTER_MOD_UD_PRESCALE_EN
  ,
  parameter int               PRE_WIDTH = 8
`endif
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] DATA,
  input  logic [WIDTH-1:0] MAX,
`ifdef COUNTER_MOD_UD_PRESCALE_EN
  input  logic [PRE_WIDTH-1:0] PRE,
`endif
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             TOG
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] o_q, o_d;
  logic             cout_q, cout_d;
  logic             tog_q, tog_d;

  // High on the edges where the main counter is allowed to move.
  logic             step;

`ifdef COUNTER_MOD_UD_PRESCALE_EN
  localparam logic [PRE_WIDTH-1:0] PRE_ONE = PRE_WIDTH'(1);

  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic                 pre_tick;

  // Prescaler: counts CE cycles 0..PRE, releasing one step at PRE. The >=
  // keeps it from running away if PRE is lowered below the current count.
  always_comb begin
    pre_d    = pre_q;
    pre_tick = 1'b0;
    if (LD) begin
      pre_d = '0;
    end else if (CE) begin
      if (pre_q >= PRE) begin
        pre_d    = '0;
        pre_tick = 1'b1;
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end
  end

  // Prescaler register; cleared by reset (load clears it in pre_d).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign step = pre_tick;
`else
  assign step = CE;
`endif

  // Next-count logic: load with clipping, else one up/down step with wrap.
  always_comb begin
    o_d    = o_q;
    cout_d = 1'b0;
    tog_d  = tog_q;
    if (LD) begin
      o_d = (DATA <= MAX) ? DATA : MAX;
    end else if (step) begin
      if (UP) begin
        // ">" covers MAX having been lowered below the current count.
        if (o_q >= MAX) begin
          o_d    = '0;
          cout_d = 1'b1;
          tog_d  = ~tog_q;
        end else begin
          o_d = o_q + ONE;
        end
      end else begin
        if (o_q == '0) begin
          o_d    = MAX;
          cout_d = 1'b1;
          tog_d  = ~tog_q;
        end else if (o_q > MAX) begin
          // Out of range after MAX was lowered: snap to MAX, not a wrap.
          o_d = MAX;
        end else begin
          o_d = o_q - ONE;
        end
      end
    end
  end

  // State registers with synchronous reset; reset drops any pending wrap.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_q    <= INIT;
      cout_q <= 1'b0;
      tog_q  <= 1'b0;
    end else begin
      o_q    <= o_d;
      cout_q <= cout_d;
      tog_q  <= tog_d;
    end
  end

  assign O    = o_q;
  assign COUT = cout_q;
  assign TOG  = tog_q;

endmodule

// File: tb/tb_counter_mod_ud.sv
// Testbench for counter_mod_ud. Main instance is WIDTH=8, INIT=5 and is
// checked every cycle against a modular-arithmetic reference model; a second
// WIDTH=24 instance covers the all-ones free-running boundary.
module tb_counter_mod_ud;

  localparam int               W      = 8;
  localparam logic [W-1:0]     INIT_V = 8'd5;

  // ---------------- clock / reset block ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         rst = 1'b1, ce = 1'b0, up = 1'b1, ld = 1'b0;
  logic [W-1:0] data = '0, max = '0;
  logic [W-1:0] o;
  logic         cout, tog;

  logic         r24 = 1'b1, ce24 = 1'b0, up24 = 1'b1, ld24 = 1'b0;
  logic [23:0]  data24 = '0, max24 = '0;
  logic [23:0]  o24;
  logic         cout24, tog24;

  counter_mod_ud #(.WIDTH(W), .INIT(INIT_V)) dut (
    .CLK(CLK), .RESET(rst), .CE(ce), .UP(up), .LD(ld),
    .DATA(data), .MAX(max),
`ifdef COUNTER_MOD_UD_PRESCALE_EN
    .PRE('0),
`endif
    .O(o), .COUT(cout), .TOG(tog)
  );

  counter_mod_ud #(.WIDTH(24), .INIT(24'd0)) dut24 (
    .CLK(CLK), .RESET(r24), .CE(ce24), .UP(up24), .LD(ld24),
    .DATA(data24), .MAX(max24),
`ifdef COUNTER_MOD_UD_PRESCALE_EN
    .PRE('0),
`endif
    .O(o24), .COUT(cout24), .TOG(tog24)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard / reference model ----------------
  // Expected {TOG, COUT, O} after each driven edge.
  logic [W+1:0] exp_q[$];
  longint       m_o    = 0;
  int           m_wraps = 0;

  // Count held as an integer in 0..MAX; a step is +/-1 modulo (MAX+1).
  // TOG is the parity of the number of wraps since reset.
  task automatic model_step(input logic r, input logic l, input logic c,
                            input logic u, input logic [W-1:0] d,
                            input logic [W-1:0] mx);
    longint m    = longint'(mx);
    logic   wrap = 1'b0;
    if (r) begin
      m_o     = longint'(INIT_V);
      m_wraps = 0;
    end else if (l) begin
      m_o = (longint'(d) > m) ? m : longint'(d);
    end else if (c) begin
      if (u) begin
        if (m_o > m) begin
          m_o  = 0;
          wrap = 1'b1;
        end else begin
          m_o  = (m_o + 1) % (m + 1);
          wrap = (m_o == 0);
        end
      end else begin
        if (m_o > m) begin
          m_o = m;
        end else begin
          wrap = (m_o == 0);
          m_o  = (m_o + m) % (m + 1);
        end
      end
    end
    if (wrap) m_wraps++;
    exp_q.push_back({m_wraps[0], wrap, W'(m_o)});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic l, input logic c,
                       input logic u, input logic [W-1:0] d,
                       input logic [W-1:0] mx);
    rst = r; ld = l; ce = c; up = u; data = d; max = mx;
    model_step(r, l, c, u, d, mx);
    @(posedge CLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W+1:0] e;
    r24 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd255);
      e = exp_q.pop_front();
      n_tests++;
      if ({tog, cout, o} !== e || o !== 8'd5 || cout !== 1'b0 || tog !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got o=%0d cout=%0b tog=%0b, expected o=5 cout=0 tog=0", i, o, cout, tog);
      end
    end
    r24 = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd255);
    e = exp_q.pop_front();
    n_tests++;
    if ({tog, cout, o} !== e || o !== 8'd6) begin
      n_fail++;
      $display("FAIL reset_release: got o=%0d cout=%0b, expected o=6 cout=0", o, cout);
    end
  endtask

  task automatic test_up_wrap();
    logic [W+1:0] e;
    int pulses = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd9);
    e = exp_q.pop_front();
    n_tests++;
    if ({tog, cout, o} !== e) begin
      n_fail++;
      $display("FAIL up_load0: got o=%0d cout=%0b tog=%0b, expected o=%0d cout=%0b tog=%0b", o, cout, tog, e[W-1:0], e[W], e[W+1]);
    end
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9);
      e = exp_q.pop_front();
      if (cout === 1'b1) pulses++;
      n_tests++;
      if ({tog, cout, o} !== e || o !== W'(i % 10)) begin
        n_fail++;
        $display("FAIL up_wrap cyc%0d: got o=%0d cout=%0b tog=%0b, expected o=%0d cout=%0b tog=%0b", i, o, cout, tog, e[W-1:0], e[W], e[W+1]);
      end
      if (i == 10 || i == 20) begin
        n_tests++;
        if (cout !== 1'b1 || tog !== (i == 10 ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL up_wrap_tog cyc%0d: got cout=%0b tog=%0b, expected cout=1 tog=%0b", i, cout, tog, (i == 10));
        end
      end
    end
    n_tests++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL up_wrap_pulses: got %0d, expected 2", pulses);
    end
  endtask

  task automatic test_down_load_clip();
    logic [W+1:0] e;
    logic [W-1:0] exp_seq[5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd9};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd9);
      else        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd9);
      e = exp_q.pop_front();
      n_tests++;
      if ({tog, cout, o} !== e || o !== exp_seq[i] || cout !== (i == 4)) begin
        n_fail++;
        $display("FAIL down_wrap step%0d: got o=%0d cout=%0b, expected o=%0d cout=%0b", i, o, cout, exp_seq[i], (i == 4));
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd200, 8'd9);
    e = exp_q.pop_front();
    n_tests++;
    if ({tog, cout, o} !== e || o !== 8'd9 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clip: got o=%0d cout=%0b, expected o=9 cout=0", o, cout);
    end
  endtask

  task automatic test_simultaneous();
    logic [W+1:0] e;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'd4, 8'd9);
    e = exp_q.pop_front();
    n_tests++;
    if ({tog, cout, o} !== e || o !== INIT_V) begin
      n_fail++;
      $display("FAIL reset_over_load: got o=%0d, expected o=%0d", o, INIT_V);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 8'd9);
    e = exp_q.pop_front();
    n_tests++;
    if ({tog, cout, o} !== e || o !== 8'd4 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL load_over_ce: got o=%0d cout=%0b, expected o=4 cout=0", o, cout);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd9);
      e = exp_q.pop_front();
      n_tests++;
      if ({tog, cout, o} !== e || o !== 8'd4 || cout !== 1'b0) begin
        n_fail++;
        $display("FAIL ce_hold cyc%0d: got o=%0d cout=%0b, expected o=4 cout=0", i, o, cout);
      end
    end
  endtask

  task automatic test_max_zero();
    logic [W+1:0] e;
    logic         prev_tog;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);
    e = exp_q.pop_front();
    prev_tog = tog;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0);
      e = exp_q.pop_front();
      n_tests++;
      if ({tog, cout, o} !== e || o !== 8'd0 || cout !== 1'b1 || tog === prev_tog) begin
        n_fail++;
        $display("FAIL max_zero cyc%0d: got o=%0d cout=%0b tog=%0b, expected o=0 cout=1 tog=%0b", i, o, cout, tog, ~prev_tog);
      end
      prev_tog = tog;
    end
  endtask

  task automatic test_max_lowered();
    logic [W+1:0] e;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 8'd9);
    e = exp_q.pop_front();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd3);
    e = exp_q.pop_front();
    n_tests++;
    if ({tog, cout, o} !== e || o !== 8'd0 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL max_lowered_up: got o=%0d cout=%0b, expected o=0 cout=1", o, cout);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 8'd9);
    e = exp_q.pop_front();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd3);
    e = exp_q.pop_front();
    n_tests++;
    if ({tog, cout, o} !== e || o !== 8'd3 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL max_lowered_down: got o=%0d cout=%0b, expected o=3 cout=0", o, cout);
    end
  endtask

  task automatic test_random();
    logic [W+1:0] e;
    logic [W-1:0] cur_max = 8'd6;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0)
        cur_max = ($urandom_range(0, 7) == 0) ? 8'd255 : W'($urandom_range(0, 12));
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
            W'($urandom_range(0, 15)), cur_max);
      e = exp_q.pop_front();
      n_tests++;
      if ({tog, cout, o} !== e) begin
        n_fail++;
        $display("FAIL random cyc%0d: got o=%0d cout=%0b tog=%0b, expected o=%0d cout=%0b tog=%0b", i, o, cout, tog, e[W-1:0], e[W], e[W+1]);
      end
    end
  endtask

  // 24-bit all-ones terminal value; the 8-bit instance idles (CE=0).
  task automatic test_boundary_24();
    logic [W+1:0] e;
    ld24 = 1'b1; ce24 = 1'b0; up24 = 1'b1; data24 = 24'hFFFFFE; max24 = 24'hFFFFFF;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd9);
    e = exp_q.pop_front();
    n_tests++;
    if (o24 !== 24'hFFFFFE || cout24 !== 1'b0) begin
      n_fail++;
      $display("FAIL w24_load: got o=%h cout=%0b, expected o=fffffe cout=0", o24, cout24);
    end
    ld24 = 1'b0; ce24 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd9);
    e = exp_q.pop_front();
    n_tests++;
    if (o24 !== 24'hFFFFFF || cout24 !== 1'b0) begin
      n_fail++;
      $display("FAIL w24_top: got o=%h cout=%0b, expected o=ffffff cout=0", o24, cout24);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd9);
    e = exp_q.pop_front();
    n_tests++;
    if (o24 !== 24'h000000 || cout24 !== 1'b1 || tog24 !== 1'b1) begin
      n_fail++;
      $display("FAIL w24_wrap: got o=%h cout=%0b tog=%0b, expected o=000000 cout=1 tog=1", o24, cout24, tog24);
    end
    ce24 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd9);
    e = exp_q.pop_front();
    n_tests++;
    if (o24 !== 24'h000000 || cout24 !== 1'b0 || tog24 !== 1'b1) begin
      n_fail++;
      $display("FAIL w24_hold: got o=%h cout=%0b tog=%0b, expected o=000000 cout=0 tog=1", o24, cout24, tog24);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_up_wrap();
    test_down_load_clip();
    test_simultaneous();
    test_max_zero();
    test_max_lowered();
    test_boundary_24();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
